// File: rtl/output_cw_stage.sv
// Clockwise output stage of a ring router node: merges ring pass-through and PE
// injection traffic into an even/odd output buffer pair that drives the cw link.
module output_cw_stage #(
    parameter int DATA_W  = 64,
    parameter int HOP_LSB = 48,
    parameter int HOP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              ring_req,
    input  logic [DATA_W-1:0] ring_d,
    output logic              ring_gnt,
    input  logic              pe_req,
    input  logic [DATA_W-1:0] pe_d,
    output logic              pe_gnt,
    input  logic              cwro,
    output logic              cwso,
    output logic [DATA_W-1:0] cwdo
);

    logic [DATA_W-1:0] buf_even_q, buf_even_d;
    logic [DATA_W-1:0] buf_odd_q, buf_odd_d;
    logic              full_even_q, full_even_d;
    logic              full_odd_q, full_odd_d;
    logic              rr_q, rr_d;

    logic              full_fill;
    logic              full_drain;
    logic              can_acc;
    logic              grant;
    logic [DATA_W-1:0] win_d;
    logic [DATA_W-1:0] shifted_d;

    // Each accepted packet moves one hop closer: hop field shifts right by one.
    function automatic logic [DATA_W-1:0] shift_hop(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        r[HOP_LSB +: HOP_W] = d[HOP_LSB +: HOP_W] >> 1;
        return r;
    endfunction

    // Polarity 0 fills even / drains odd; polarity 1 is the mirror image.
    always_comb begin
        full_fill  = polarity ? full_odd_q : full_even_q;
        full_drain = polarity ? full_even_q : full_odd_q;
        cwdo       = polarity ? buf_even_q : buf_odd_q;
        cwso       = full_drain & cwro;
        can_acc    = !full_fill;
        ring_gnt   = can_acc & ring_req & (!pe_req | !rr_q);
        pe_gnt     = can_acc & pe_req & (!ring_req | rr_q);
        grant      = ring_gnt | pe_gnt;
        win_d      = ring_gnt ? ring_d : pe_d;
        shifted_d  = shift_hop(win_d);
    end

    always_comb begin
        buf_even_d  = buf_even_q;
        buf_odd_d   = buf_odd_q;
        full_even_d = full_even_q;
        full_odd_d  = full_odd_q;
        rr_d        = rr_q;

        if (cwso) begin
            if (polarity) full_even_d = 1'b0;
            else          full_odd_d  = 1'b0;
        end

        if (grant) begin
            if (polarity) begin
                buf_odd_d  = shifted_d;
                full_odd_d = 1'b1;
            end else begin
                buf_even_d  = shifted_d;
                full_even_d = 1'b1;
            end
            rr_d = ring_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_even_q  <= '0;
            buf_odd_q   <= '0;
            full_even_q <= 1'b0;
            full_odd_q  <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            buf_even_q  <= buf_even_d;
            buf_odd_q   <= buf_odd_d;
            full_even_q <= full_even_d;
            full_odd_q  <= full_odd_d;
            rr_q        <= rr_d;
        end
    end

endmodule

// File: tb/tb_output_cw_stage.sv
// Directed bench for output_cw_stage: expected link data is queued at grant time
// and checked against cwdo whenever a transfer is expected.
module tb_output_cw_stage;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        ring_req;
    logic [63:0] ring_d;
    logic        ring_gnt;
    logic        pe_req;
    logic [63:0] pe_d;
    logic        pe_gnt;
    logic        cwro;
    logic        cwso;
    logic [63:0] cwdo;

    int          checks;
    int          errors;
    logic [63:0] sb_q[$];

    output_cw_stage #(.DATA_W(64), .HOP_LSB(48), .HOP_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .ring_req (ring_req),
        .ring_d   (ring_d),
        .ring_gnt (ring_gnt),
        .pe_req   (pe_req),
        .pe_d     (pe_d),
        .pe_gnt   (pe_gnt),
        .cwro     (cwro),
        .cwso     (cwso),
        .cwdo     (cwdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pkt(input logic [7:0] hi, input logic [7:0] hop,
                                        input logic [47:0] lo);
        return {hi, hop, lo};
    endfunction

    function automatic logic [63:0] expect_hop(input logic [63:0] d);
        return {d[63:56], 1'b0, d[55:49], d[47:0]};
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check combinational outputs 1ns later,
    // the state update then happens at the following rising edge.
    task automatic step(input string tag, input logic rst, input logic pol,
                        input logic rreq, input logic [63:0] rd,
                        input logic preq, input logic [63:0] pd, input logic cw,
                        input logic exp_r, input logic exp_p, input logic exp_so,
                        input logic exp_zero);
        logic [63:0] front;
        @(negedge clk);
        reset    = rst;
        polarity = pol;
        ring_req = rreq;
        ring_d   = rd;
        pe_req   = preq;
        pe_d     = pd;
        cwro     = cw;
        #1;
        check_bit({tag, " ring_gnt"}, ring_gnt, exp_r);
        check_bit({tag, " pe_gnt"}, pe_gnt, exp_p);
        check_bit({tag, " cwso"}, cwso, exp_so);
        if (exp_zero) check_word({tag, " cwdo_zero"}, cwdo, 64'h0);
        if (exp_so) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s scoreboard empty observed=%h expected=none", tag, cwdo);
            end else begin
                front = sb_q.pop_front();
                check_word({tag, " cwdo"}, cwdo, front);
            end
        end
        if (exp_r) sb_q.push_back(expect_hop(rd));
        if (exp_p) sb_q.push_back(expect_hop(pd));
    endtask

    initial begin
        logic [63:0] r0, r1, p0, p1, b0, b1, b2, b3, s0, s1, d1, x0, x1, z0;
        checks = 0;
        errors = 0;
        reset = 1'b0; polarity = 1'b0; ring_req = 1'b0; ring_d = '0;
        pe_req = 1'b0; pe_d = '0; cwro = 1'b0;

        d1 = pkt(8'hA5, 8'h06, 48'h1234_5678_9ABC);
        r0 = pkt(8'h11, 8'hF0, 48'h0000_0000_0001);
        r1 = pkt(8'h12, 8'h81, 48'h0000_0000_0002);
        p0 = pkt(8'h21, 8'h0F, 48'hFFFF_0000_0003);
        p1 = pkt(8'h22, 8'hFF, 48'hFFFF_0000_0004);
        b0 = pkt(8'h31, 8'h02, 48'hABCD_0000_0005);
        b1 = pkt(8'h32, 8'h04, 48'hABCD_0000_0006);
        b2 = pkt(8'h33, 8'h08, 48'hABCD_0000_0007);
        b3 = pkt(8'h34, 8'h10, 48'hABCD_0000_0008);
        s0 = pkt(8'h41, 8'h20, 48'h5555_AAAA_0009);
        s1 = pkt(8'h42, 8'h40, 48'h5555_AAAA_000A);
        x0 = pkt(8'h51, 8'h03, 48'h0F0F_0F0F_000B);
        x1 = pkt(8'h52, 8'h05, 48'h0F0F_0F0F_000C);
        z0 = pkt(8'h61, 8'h80, 48'h1111_2222_000D);

        @(posedge clk);
        // tag         rst  pol  rreq rd  preq pd  cwro gr   gp   so   zero
        step("rst0",   0,   0,   0,  '0,  0,  '0,  1,   0,   0,   0,   1);
        step("rst1",   0,   1,   0,  '0,  0,  '0,  1,   0,   0,   0,   1);

        step("single_gnt", 1, 0, 1, d1,  0,  '0,  1,   1,   0,   0,   0);
        step("single_out", 1, 1, 0, '0,  0,  '0,  1,   0,   0,   1,   0);
        step("rr_clear",   0, 0, 0, '0,  0,  '0,  1,   0,   0,   0,   0);

        step("cont0", 1, 1, 1, r0, 1, p0, 1, 1, 0, 0, 0);
        step("cont1", 1, 0, 1, r1, 1, p0, 1, 0, 1, 1, 0);
        step("cont2", 1, 1, 1, r1, 1, p1, 1, 1, 0, 1, 0);
        step("cont3", 1, 0, 0, '0, 1, p1, 1, 0, 1, 1, 0);
        step("cont4", 1, 1, 0, '0, 0, '0, 1, 0, 0, 1, 0);

        step("bp0", 1, 0, 1, b0, 0, '0, 0, 1, 0, 0, 0);
        step("bp1", 1, 1, 1, b1, 0, '0, 0, 1, 0, 0, 0);
        step("bp2", 1, 0, 1, b2, 0, '0, 0, 0, 0, 0, 0);
        step("bp3", 1, 1, 1, b2, 0, '0, 0, 0, 0, 0, 0);
        step("bp4", 1, 0, 1, b2, 0, '0, 0, 0, 0, 0, 0);
        step("bp5", 1, 1, 1, b2, 0, '0, 1, 0, 0, 1, 0);
        step("bp6", 1, 0, 1, b2, 0, '0, 1, 1, 0, 1, 0);
        step("bp7", 1, 1, 1, b3, 0, '0, 1, 1, 0, 1, 0);
        step("bp8", 1, 0, 0, '0, 0, '0, 1, 0, 0, 1, 0);

        step("sim0", 1, 1, 0, '0, 1, s0, 1, 0, 1, 0, 0);
        step("sim1", 1, 0, 0, '0, 1, s1, 1, 0, 1, 1, 0);
        step("sim2", 1, 1, 0, '0, 0, '0, 1, 0, 0, 1, 0);

        step("mid0", 1, 0, 1, x0, 0, '0, 0, 1, 0, 0, 0);
        step("mid1", 1, 1, 1, x1, 0, '0, 0, 1, 0, 0, 0);
        step("mid_rst", 0, 0, 0, '0, 0, '0, 0, 0, 0, 0, 0);
        sb_q.delete();
        step("post0", 1, 1, 0, '0, 0, '0, 1, 0, 0, 0, 1);
        step("post1", 1, 0, 0, '0, 0, '0, 1, 0, 0, 0, 1);
        step("post_rr", 1, 1, 1, z0, 1, p0, 1, 1, 0, 0, 0);
        step("post_out", 1, 0, 0, '0, 1, p0, 1, 0, 1, 1, 0);
        step("post_end", 1, 1, 0, '0, 0, '0, 1, 0, 0, 1, 0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
